// File: rtl/hamming_pkg.sv
// hamming_pkg: code-size derivation and position-mapping helpers shared with createGeneratorMatrix
package hamming_pkg;
   localparam int M_DEF = 4;
   function automatic int calc_n(input int m);
      return (1 << m) - 1;
   endfunction
   function automatic int calc_k(input int m);
      return calc_n(m) - m;
   endfunction
   function automatic logic is_pow2(input int x);
      return x > 0 && (x & (x - 1)) == 0;
   endfunction
   // Hamming position of data bit r: the r-th non-power-of-2 position, ascending from 3
   function automatic int data_pos(input int r);
      int c = 0;
      int pos = 0;
      for (int p = 3; p < 64; p++)
         if (!is_pow2(p)) begin
            if (c == r && pos == 0) pos = p;
            c++;
         end
      return pos;
   endfunction
   // inverse of data_pos for a non-power-of-2 position (subtract the parity slots at or below p)
   function automatic int pos_to_data_idx(input int p);
      return p - $clog2(p + 1) - 1;
   endfunction
   // data bits whose Hamming position has bit b set
   function automatic int data_mask(input int m, input int b);
      int mask = 0;
      for (int r = 0; r < calc_k(m); r++)
         if (((data_pos(r) >> b) & 1) == 1) mask = mask | (32'sd1 << r);
      return mask;
   endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational syndrome S and overall parity P of an extended Hamming codeword
//   cw  in   codeword ([K-1:0] data, [K+M-1:K] parity p0..p(M-1), [K+M] overall parity)
//   s   out  syndrome, value 1..N names the flipped Hamming position
//   p   out  XOR of every codeword bit
module hamming_syndrome import hamming_pkg::*; #(
   parameter int M = M_DEF
) (
   input  logic [calc_n(M):0] cw,
   output logic [M-1:0]       s,
   output logic               p
);
   localparam int K = calc_k(M);
   // syndrome bit b is checked by parity p(M-1-b), which covers Hamming position 2**b
   for (genvar b = 0; b < M; b++) begin : g_s
      localparam int MASK = data_mask(M, b);
      assign s[b] = cw[K + M - 1 - b] ^ ^(cw[K-1:0] & MASK[K-1:0]);
   end
   assign p = ^cw;
endmodule

// File: rtl/extended_hamming_decoder.sv
// extended_hamming_decoder: 2-stage SECDED decoder with valid/ready handshake and error counters
//   clk, reset            clock and asynchronous active-high reset
//   cw_in/valid/ready     codeword input handshake
//   data_out/out_valid/ready  corrected data output handshake
//   err_single/double/pos flags and syndrome travelling with data_out
//   count_clr             synchronous clear of corr_count and dbl_count
//   corr_count/dbl_count  saturating counts of accepted single/double error outputs
module extended_hamming_decoder import hamming_pkg::*; #(
   parameter int M = M_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [calc_n(M):0]   cw_in,
   input  logic                 cw_valid,
   output logic                 cw_ready,
   output logic [calc_k(M)-1:0] data_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 err_single,
   output logic                 err_double,
   output logic [M-1:0]         err_pos,
   input  logic                 count_clr,
   output logic [15:0]          corr_count,
   output logic [15:0]          dbl_count
);
   localparam int K = calc_k(M);
   logic [M-1:0] syn_s, s1_s;
   logic         syn_p, s1_p, s1_valid;
   logic [K-1:0] s1_data, flip;
   logic         s2_adv, s1_adv, out_xfer;
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign cw_ready = s1_adv;
   assign out_xfer = out_valid && out_ready;
   hamming_syndrome #(.M(M)) u_syn (.cw(cw_in), .s(syn_s), .p(syn_p));
   // a power-of-2 syndrome names a parity bit, which matches no data position and so flips nothing
   for (genvar r = 0; r < K; r++) begin : g_fix
      localparam int POS = data_pos(r);
      assign flip[r] = s1_p && s1_s == POS[M-1:0];
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_s     <= '0;
         s1_p     <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= cw_valid;
         s1_data  <= cw_in[K-1:0];
         s1_s     <= syn_s;
         s1_p     <= syn_p;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         out_valid  <= 1'b0;
         data_out   <= '0;
         err_single <= 1'b0;
         err_double <= 1'b0;
         err_pos    <= '0;
      end else if (s2_adv) begin
         out_valid  <= s1_valid;
         data_out   <= s1_data ^ flip;
         err_single <= s1_p;
         err_double <= !s1_p && s1_s != '0;
         err_pos    <= s1_s;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         corr_count <= '0;
         dbl_count  <= '0;
      end else begin
         corr_count <= count_clr ? '0 : corr_count + 16'(out_xfer && err_single && corr_count != 16'hFFFF);
         dbl_count  <= count_clr ? '0 : dbl_count + 16'(out_xfer && err_double && dbl_count != 16'hFFFF);
      end
endmodule

// File: tb/tb_extended_hamming_decoder.sv
// tb_extended_hamming_decoder: directed scoreboard bench for the SECDED decoder (M=4)
module tb_extended_hamming_decoder;
   typedef struct packed {
      logic [10:0] d;
      logic        s;
      logic        db;
      logic [3:0]  p;
   } exp_t;
   logic        clk = 0, reset = 1, cw_valid = 0, out_ready = 1, count_clr = 0;
   logic [15:0] cw_in = '0;
   logic        cw_ready, out_valid, err_single, err_double;
   logic [10:0] data_out;
   logic [3:0]  err_pos;
   logic [15:0] corr_count, dbl_count;
   exp_t        q[$];
   exp_t        e;
   int          n_chk = 0, n_fail = 0;
   logic        hold = 0;
   logic [16:0] prev;
   logic [15:0] scw[8];
   exp_t        sexp[8];

   extended_hamming_decoder #(.M(4)) dut (
      .clk(clk), .reset(reset), .cw_in(cw_in), .cw_valid(cw_valid), .cw_ready(cw_ready),
      .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
      .err_single(err_single), .err_double(err_double), .err_pos(err_pos),
      .count_clr(count_clr), .corr_count(corr_count), .dbl_count(dbl_count)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [10:0] d, input logic s, input logic db, input logic [3:0] p);
      return {d, s, db, p};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   // inputs change on negedge; cw_ready is sampled 1 time unit later, well before the posedge
   task automatic send(input logic [15:0] c, input exp_t x);
      int t = 0;
      cw_in = c;
      cw_valid = 1;
      #1;
      while (!cw_ready && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!cw_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: cw_ready stuck low for codeword %h", c);
      end else q.push_back(x);
      @(negedge clk);
      cw_valid = 0;
   endtask

   task automatic wait_empty();
      int t = 0;
      while (q.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d outputs never appeared", q.size());
         q.delete();
      end
      repeat (2) @(negedge clk);
      #1;
   endtask

   // monitor: transfer happens at the next posedge iff out_valid & out_ready here
   initial forever begin
      @(negedge clk);
      #2;
      if (!out_valid) hold = 0;
      else begin
         if (hold) chk("stable", {data_out, err_single, err_double, err_pos}, prev);
         if (out_ready) begin
            hold = 0;
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: data %h pos %h", data_out, err_pos);
            end else begin
               e = q.pop_front();
               chk("out", {data_out, err_single, err_double, err_pos}, e);
               chk("excl", err_single & err_double, 0);
            end
         end else begin
            hold = 1;
            prev = {data_out, err_single, err_double, err_pos};
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      scw = '{16'hE001, 16'hD002, 16'hB004, 16'h7008, 16'hC810, 16'h0000, 16'hE000, 16'hD003};
      sexp = '{mk(11'h001, 0, 0, 0), mk(11'h002, 0, 0, 0), mk(11'h004, 0, 0, 0), mk(11'h008, 0, 0, 0),
               mk(11'h010, 0, 0, 0), mk(11'h000, 0, 0, 0), mk(11'h001, 1, 0, 3), mk(11'h002, 1, 0, 3)};
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_data", data_out, 0);
      chk("rst_pos", err_pos, 0);
      chk("rst_corr", corr_count, 0);
      chk("rst_dbl", dbl_count, 0);
      @(negedge clk);
      reset = 0;
      #1;
      chk("rst_cw_ready", cw_ready, 1);
      @(negedge clk);
      send(16'hE001, mk(11'h001, 0, 0, 0));
      #1;
      chk("lat1_out_valid", out_valid, 0);
      @(negedge clk);
      #1;
      chk("lat2_out_valid", out_valid, 1);
      @(negedge clk);
      send(16'hE000, mk(11'h001, 1, 0, 3));
      send(16'hA001, mk(11'h001, 1, 0, 1));
      send(16'h6001, mk(11'h001, 1, 0, 0));
      send(16'hE002, mk(11'h002, 0, 1, 6));
      wait_empty();
      chk("corr_count_a", corr_count, 3);
      chk("dbl_count_a", dbl_count, 1);
      @(negedge clk);
      fork
         for (int i = 0; i < 8; i++) send(scw[i], sexp[i]);
         begin
            repeat (4) @(negedge clk);
            out_ready = 0;
            @(negedge clk);
            #1;
            chk("stall_cw_ready", cw_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            repeat (2) @(negedge clk);
            out_ready = 1;
         end
      join
      wait_empty();
      chk("corr_count_b", corr_count, 5);
      chk("dbl_count_b", dbl_count, 1);
      @(negedge clk);
      out_ready = 0;
      send(16'hE000, mk(11'h001, 1, 0, 3));
      send(16'hE000, mk(11'h001, 1, 0, 3));
      reset = 1;
      #1;
      q.delete();
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_data", data_out, 0);
      chk("midrst_corr", corr_count, 0);
      chk("midrst_dbl", dbl_count, 0);
      @(negedge clk);
      reset = 0;
      out_ready = 1;
      #1;
      chk("midrst_cw_ready", cw_ready, 1);
      repeat (3) @(negedge clk);
      #1;
      chk("midrst_no_output", out_valid, 0);
      @(negedge clk);
      send(16'hE000, mk(11'h001, 1, 0, 3));
      wait_empty();
      chk("corr_count_c", corr_count, 1);
      @(negedge clk);
      send(16'hE000, mk(11'h001, 1, 0, 3));
      @(negedge clk);
      count_clr = 1;
      #1;
      chk("clr_out_valid", out_valid, 1);
      @(negedge clk);
      count_clr = 0;
      #1;
      chk("clr_corr_count", corr_count, 0);
      wait_empty();
      chk("clr_dbl_count", dbl_count, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
